// File: rtl/hex_word_entry.sv
// Keypad-style hex word assembler: nibbles shift in on digit presses and
// a commit press offers the finished word to the processor via valid/ready.
module hex_word_entry #(
  parameter int DIGITS = 8
) (
  input  logic                  clk_27,
  input  logic                  reset_n,
  input  logic [3:0]            nibble_in,
  input  logic                  digit_btn,
  input  logic                  commit_btn,
  input  logic                  clear_btn,
  input  logic                  word_ready,
  output logic [4*DIGITS-1:0]   entry_value,
  output logic [3:0]            digit_count,
  output logic                  entry_full,
  output logic [4*DIGITS-1:0]   word_out,
  output logic                  word_valid,
  output logic                  overflow_err
);

  localparam int W = 4 * DIGITS;

  // One-hot so that any corrupted encoding is detectable and recoverable.
  typedef enum logic [1:0] {
    ENTRY = 2'b01,
    OFFER = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   entry_q, entry_d;
  logic [3:0]     count_q, count_d;
  logic [W-1:0]   word_q, word_d;
  logic           valid_q, valid_d;
  logic           ovf_q, ovf_d;
  logic           dig_prev_q, dig_prev_d;
  logic           cmt_prev_q, cmt_prev_d;
  logic           clr_prev_q, clr_prev_d;

  logic dig_press;
  logic cmt_press;
  logic clr_press;
  logic is_full;
  logic in_entry;

  assign dig_press = digit_btn & ~dig_prev_q;
  assign cmt_press = commit_btn & ~cmt_prev_q;
  assign clr_press = clear_btn & ~clr_prev_q;
  assign is_full   = (count_q == 4'(DIGITS));

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    word_d     = word_q;
    valid_d    = valid_q;
    ovf_d      = 1'b0;
    in_entry   = 1'b0;
    dig_prev_d = digit_btn;
    cmt_prev_d = commit_btn;
    clr_prev_d = clear_btn;

    unique case (state_q)
      ENTRY: begin
        in_entry = 1'b1;
        valid_d  = 1'b0;
      end
      OFFER: begin
        valid_d = 1'b1;
        if (word_ready) begin
          state_d = ENTRY;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ENTRY;
        valid_d = 1'b0;
      end
    endcase

    // Only the highest-priority press acts; the rest are dropped.
    priority case (1'b1)
      clr_press: begin
        entry_d = '0;
        count_d = '0;
      end
      cmt_press: begin
        if (in_entry && count_q != 4'd0) begin
          word_d  = entry_q;
          valid_d = 1'b1;
          state_d = OFFER;
          entry_d = '0;
          count_d = '0;
        end
      end
      dig_press: begin
        if (!is_full) begin
          entry_d = {entry_q[W-5:0], nibble_in};
          count_d = count_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ENTRY;
      entry_q    <= '0;
      count_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      // Held buttons at reset release must not count as presses.
      dig_prev_q <= 1'b1;
      cmt_prev_q <= 1'b1;
      clr_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      dig_prev_q <= dig_prev_d;
      cmt_prev_q <= cmt_prev_d;
      clr_prev_q <= clr_prev_d;
    end
  end

  assign entry_value  = entry_q;
  assign digit_count  = count_q;
  assign entry_full   = is_full;
  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_hex_word_entry.sv
// Scoreboard bench for hex_word_entry: a nibble-queue reference model
// predicts entry state and offered words under directed and random presses.
module tb_hex_word_entry;

  logic        clk_27;
  logic        reset_n;
  logic [3:0]  nibble_in;
  logic        digit_btn;
  logic        commit_btn;
  logic        clear_btn;
  logic        word_ready;
  logic [31:0] entry_value;
  logic [3:0]  digit_count;
  logic        entry_full;
  logic [31:0] word_out;
  logic        word_valid;
  logic        overflow_err;

  hex_word_entry #(.DIGITS(8)) dut (
    .clk_27       (clk_27),
    .reset_n      (reset_n),
    .nibble_in    (nibble_in),
    .digit_btn    (digit_btn),
    .commit_btn   (commit_btn),
    .clear_btn    (clear_btn),
    .word_ready   (word_ready),
    .entry_value  (entry_value),
    .digit_count  (digit_count),
    .entry_full   (entry_full),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .overflow_err (overflow_err)
  );

  initial clk_27 = 1'b0;
  always #5 clk_27 = ~clk_27;

  int checks = 0;
  int errors = 0;

  logic [3:0]  digits[$];
  logic [31:0] sb[$];
  logic        m_offer;
  logic        m_ovf;
  logic [31:0] m_word;
  logic        pd, pc, pl;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_value();
    logic [31:0] v = 32'd0;
    foreach (digits[i]) v = v * 16 + 32'(digits[i]);
    return v;
  endfunction

  task automatic model_reset();
    digits.delete();
    sb.delete();
    m_offer = 1'b0;
    m_ovf   = 1'b0;
    m_word  = 32'd0;
    pd = 1'b1;
    pc = 1'b1;
    pl = 1'b1;
  endtask

  task automatic model_edge();
    logic dp, cp, lp, was_offer;
    dp = digit_btn & ~pd;
    cp = commit_btn & ~pc;
    lp = clear_btn & ~pl;
    pd = digit_btn;
    pc = commit_btn;
    pl = clear_btn;
    was_offer = m_offer;
    m_ovf = 1'b0;
    if (m_offer && word_ready) m_offer = 1'b0;
    if (lp) begin
      digits.delete();
    end else if (cp) begin
      if (!was_offer && digits.size() > 0) begin
        m_word  = m_value();
        m_offer = 1'b1;
        sb.push_back(m_word);
        digits.delete();
      end
    end else if (dp) begin
      if (digits.size() < 8) digits.push_back(nibble_in);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk_27);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic press_digit(input logic [3:0] n);
    nibble_in = n;
    digit_btn = 1'b1;
    tick();
    digit_btn = 1'b0;
    tick();
  endtask

  task automatic press_commit();
    commit_btn = 1'b1;
    tick();
    commit_btn = 1'b0;
    tick();
  endtask

  task automatic press_clear();
    clear_btn = 1'b1;
    tick();
    clear_btn = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_entry", entry_value, 32'd0);
    check("rst_word", word_out, 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Monitor: compares DUT against the model mid-cycle, pops on handshake.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk_27);
      check("entry_value", entry_value, m_value());
      check("digit_count", 32'(digit_count), 32'(digits.size()));
      check("entry_full", 32'(entry_full), 32'(digits.size() == 8));
      check("overflow_err", 32'(overflow_err), 32'(m_ovf));
      check("word_valid", 32'(word_valid), 32'(m_offer));
      if (word_valid) check("word_out_hold", word_out, m_word);
      if (word_valid && word_ready && reset_n) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          check("transfer", word_out, exp);
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    nibble_in  = 4'h0;
    digit_btn  = 1'b1;
    commit_btn = 1'b0;
    clear_btn  = 1'b0;
    word_ready = 1'b0;
    model_reset();
    #2;
    do_reset();
    tick();
    tick();
    check("held_digit_count", 32'(digit_count), 32'd0);
    digit_btn = 1'b0;
    tick();

    for (int i = 1; i <= 8; i++) press_digit(4'(i));
    press_commit();
    check("word_12345678", word_out, 32'h12345678);
    check("valid_after_commit", 32'(word_valid), 32'd1);
    check("entry_cleared", entry_value, 32'd0);
    tick();
    tick();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("valid_dropped", 32'(word_valid), 32'd0);
    tick();

    for (int i = 0; i < 8; i++) press_digit(4'(15 - i));
    nibble_in = 4'h9;
    digit_btn = 1'b1;
    tick();
    check("ovf_pulse", 32'(overflow_err), 32'd1);
    check("ovf_entry", entry_value, 32'hFEDCBA98);
    check("ovf_full", 32'(entry_full), 32'd1);
    digit_btn = 1'b0;
    tick();
    check("ovf_one_cycle", 32'(overflow_err), 32'd0);
    press_clear();

    press_digit(4'hC);
    press_digit(4'hA);
    press_digit(4'hF);
    press_digit(4'hE);
    press_commit();
    press_digit(4'hA);
    press_digit(4'hB);
    check("offer_entry_ab", entry_value, 32'h000000AB);
    check("offer_word_cafe", word_out, 32'h0000CAFE);
    press_commit();
    check("commit_in_offer", word_out, 32'h0000CAFE);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    tick();
    press_commit();
    check("word_ab", word_out, 32'h000000AB);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    tick();

    press_digit(4'h1);
    press_digit(4'h2);
    press_digit(4'h3);
    clear_btn  = 1'b1;
    commit_btn = 1'b1;
    digit_btn  = 1'b1;
    tick();
    clear_btn  = 1'b0;
    commit_btn = 1'b0;
    digit_btn  = 1'b0;
    check("simul_entry", entry_value, 32'd0);
    check("simul_count", 32'(digit_count), 32'd0);
    check("simul_valid", 32'(word_valid), 32'd0);
    tick();

    press_commit();
    check("empty_commit", 32'(word_valid), 32'd0);
    press_digit(4'h5);
    press_commit();
    check("offer_5", 32'(word_valid), 32'd1);
    do_reset();
    tick();

    for (int c = 0; c < 3000; c++) begin
      nibble_in  = 4'($urandom_range(0, 15));
      digit_btn  = ($urandom_range(0, 1) == 0);
      commit_btn = ($urandom_range(0, 5) == 0);
      clear_btn  = ($urandom_range(0, 23) == 0);
      word_ready = ($urandom_range(0, 2) == 0);
      if (c == 1500) do_reset();
      else tick();
    end

    digit_btn  = 1'b0;
    commit_btn = 1'b0;
    clear_btn  = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
